// File: rtl/vend_pkg.sv
// Shared types and constants for the vending transaction controller.
package vend_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StCredit,
    StCheck,
    StDispense,
    StPayout,
    StDone
  } vend_state_e;

  typedef enum logic [1:0] {
    PayIdle,
    PayPick,
    PayReq
  } pay_state_e;

  localparam logic [1:0] ItemCancel = 2'd0;
  localparam logic [1:0] ItemCoke   = 2'd1;
  localparam logic [1:0] ItemWater  = 2'd2;
  localparam logic [1:0] ItemSnacks = 2'd3;

  localparam int unsigned DefPriceCoke   = 40;
  localparam int unsigned DefPriceWater  = 20;
  localparam int unsigned DefPriceSnacks = 50;

  localparam logic [3:0] CoinTen  = 4'd10;
  localparam logic [3:0] CoinFive = 4'd5;
  localparam logic [3:0] CoinOne  = 4'd1;

endpackage

// File: rtl/vend_change_payout.sv
// Pays out an amount coin-by-coin (greedy 10/5/1) over the hopper req/ack handshake.
module vend_change_payout
  import vend_pkg::*;
#(
  parameter int unsigned CREDIT_W = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start_i,
  input  logic [CREDIT_W-1:0] amount_i,
  input  logic                chg_ack_i,
  output logic                chg_req_o,
  output logic [3:0]          chg_coin_o,
  output logic [CREDIT_W-1:0] remain_o,
  output logic                done_o
);

  pay_state_e          state_q, state_d;
  logic [CREDIT_W-1:0] remain_q, remain_d;
  logic [3:0]          coin;

  // remain_q only changes on ack, so the chosen coin is stable while chg_req_o is high
  always_comb begin
    if (remain_q >= CREDIT_W'(CoinTen)) begin
      coin = CoinTen;
    end else if (remain_q >= CREDIT_W'(CoinFive)) begin
      coin = CoinFive;
    end else begin
      coin = CoinOne;
    end
  end

  always_comb begin
    state_d   = state_q;
    remain_d  = remain_q;
    chg_req_o = 1'b0;
    done_o    = 1'b0;
    case (state_q)
      PayIdle: begin
        if (start_i) begin
          remain_d = amount_i;
          state_d  = PayPick;
        end
      end
      PayPick: begin
        if (remain_q == '0) begin
          done_o  = 1'b1;
          state_d = PayIdle;
        end else begin
          state_d = PayReq;
        end
      end
      PayReq: begin
        chg_req_o = 1'b1;
        if (chg_ack_i) begin
          remain_d = remain_q - CREDIT_W'(coin);
          state_d  = PayPick;
        end
      end
      default: state_d = PayIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= PayIdle;
      remain_q <= '0;
    end else begin
      state_q  <= state_d;
      remain_q <= remain_d;
    end
  end

  assign chg_coin_o = chg_req_o ? coin : 4'd0;
  assign remain_o   = remain_q;

endmodule

// File: rtl/vend_txn_controller.sv
// Vending transaction sequencer: credit, price check, dispense handshake, change payout.
// Optional inactivity refund in CREDIT enabled by defining VEND_TIMEOUT_REFUND_EN.
module vend_txn_controller
  import vend_pkg::*;
#(
  parameter int unsigned CREDIT_W       = 8,
  parameter int unsigned PRICE_COKE     = DefPriceCoke,
  parameter int unsigned PRICE_WATER    = DefPriceWater,
  parameter int unsigned PRICE_SNACKS   = DefPriceSnacks,
  parameter int unsigned TIMEOUT_CYCLES = 1000
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                coin_valid_i,
  input  logic [3:0]          coin_value_i,
  input  logic                sel_valid_i,
  input  logic [1:0]          sel_item_i,
  output logic                disp_req_o,
  output logic [1:0]          disp_item_o,
  input  logic                disp_done_i,
  output logic                chg_req_o,
  output logic [3:0]          chg_coin_o,
  input  logic                chg_ack_i,
  output logic [CREDIT_W-1:0] credit_o,
  output logic                coin_reject_o,
  output logic                err_funds_o,
  output logic                vend_done_o,
  output logic                busy_o
);

  vend_state_e         state_q, state_d;
  logic [CREDIT_W-1:0] credit_q, credit_d;
  logic [1:0]          item_q, item_d;
  logic                coin_reject_q, coin_reject_d;
  logic                err_funds_q, err_funds_d;
  logic                pay_start, pay_done;
  logic [CREDIT_W-1:0] pay_remain;
  logic [CREDIT_W-1:0] price;
  logic [CREDIT_W:0]   coin_sum;
  logic                tmo_hit;

  // One extra bit so an overflowing sum is detected instead of wrapping
  assign coin_sum = {1'b0, credit_q} + {{(CREDIT_W-3){1'b0}}, coin_value_i};

  always_comb begin
    case (item_q)
      ItemCoke:   price = CREDIT_W'(PRICE_COKE);
      ItemWater:  price = CREDIT_W'(PRICE_WATER);
      ItemSnacks: price = CREDIT_W'(PRICE_SNACKS);
      default:    price = '0;
    endcase
  end

`ifdef VEND_TIMEOUT_REFUND_EN
  localparam int unsigned TmoW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TmoW-1:0] tmo_q, tmo_d;
  logic            quiet_credit;

  assign quiet_credit = (state_q == StCredit) && !coin_valid_i && !sel_valid_i;
  assign tmo_hit      = quiet_credit && (tmo_q == TmoW'(TIMEOUT_CYCLES - 1));

  always_comb begin
    tmo_d = '0;
    if (quiet_credit) begin
      tmo_d = tmo_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tmo_q <= '0;
    end else begin
      tmo_q <= tmo_d;
    end
  end
`else
  logic unused_tmo_cfg;
  assign unused_tmo_cfg = ^TIMEOUT_CYCLES;
  assign tmo_hit        = 1'b0;
`endif

  always_comb begin
    state_d       = state_q;
    credit_d      = credit_q;
    item_d        = item_q;
    coin_reject_d = 1'b0;
    err_funds_d   = 1'b0;
    pay_start     = 1'b0;
    case (state_q)
      StIdle: begin
        if (coin_valid_i) begin
          credit_d = CREDIT_W'(coin_value_i);
          state_d  = StCredit;
        end
      end
      StCredit: begin
        // A coin in the same cycle as a selection wins; the selection is dropped
        if (coin_valid_i) begin
          if (coin_sum[CREDIT_W]) begin
            coin_reject_d = 1'b1;
          end else begin
            credit_d = coin_sum[CREDIT_W-1:0];
          end
        end else if (sel_valid_i) begin
          if (sel_item_i == ItemCancel) begin
            state_d   = StPayout;
            pay_start = 1'b1;
          end else begin
            item_d  = sel_item_i;
            state_d = StCheck;
          end
        end else if (tmo_hit) begin
          state_d   = StPayout;
          pay_start = 1'b1;
        end
      end
      StCheck: begin
        if (credit_q >= price) begin
          credit_d = credit_q - price;
          state_d  = StDispense;
        end else begin
          err_funds_d = 1'b1;
          state_d     = StCredit;
        end
      end
      StDispense: begin
        if (disp_done_i) begin
          if (credit_q != '0) begin
            state_d   = StPayout;
            pay_start = 1'b1;
          end else begin
            state_d = StDone;
          end
        end
      end
      StPayout: begin
        if (pay_done) begin
          credit_d = '0;
          state_d  = StDone;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase

    if (coin_valid_i && (state_q inside {StCheck, StDispense, StPayout, StDone})) begin
      coin_reject_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= StIdle;
      credit_q      <= '0;
      item_q        <= '0;
      coin_reject_q <= 1'b0;
      err_funds_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      credit_q      <= credit_d;
      item_q        <= item_d;
      coin_reject_q <= coin_reject_d;
      err_funds_q   <= err_funds_d;
    end
  end

  vend_change_payout #(
    .CREDIT_W(CREDIT_W)
  ) u_payout (
    .clk       (clk),
    .rst       (rst),
    .start_i   (pay_start),
    .amount_i  (credit_q),
    .chg_ack_i (chg_ack_i),
    .chg_req_o (chg_req_o),
    .chg_coin_o(chg_coin_o),
    .remain_o  (pay_remain),
    .done_o    (pay_done)
  );

  assign busy_o        = state_q inside {StCheck, StDispense, StPayout};
  assign disp_req_o    = (state_q == StDispense);
  assign disp_item_o   = disp_req_o ? item_q : 2'd0;
  assign vend_done_o   = (state_q == StDone);
  assign credit_o      = (state_q == StPayout) ? pay_remain : credit_q;
  assign coin_reject_o = coin_reject_q;
  assign err_funds_o   = err_funds_q;

endmodule

// File: tb/tb_vend_txn_controller.sv
// Bench for vend_txn_controller: transaction-level model of credit, dispenses and change coins.
module tb_vend_txn_controller;

  logic       clk = 1'b0;
  logic       rst;
  logic       coin_valid_i, sel_valid_i, disp_done_i, chg_ack_i;
  logic [3:0] coin_value_i;
  logic [1:0] sel_item_i;
  logic       disp_req_o, chg_req_o, coin_reject_o, err_funds_o, vend_done_o, busy_o;
  logic [1:0] disp_item_o;
  logic [3:0] chg_coin_o;
  logic [7:0] credit_o;

  vend_txn_controller dut (
    .clk          (clk),
    .rst          (rst),
    .coin_valid_i (coin_valid_i),
    .coin_value_i (coin_value_i),
    .sel_valid_i  (sel_valid_i),
    .sel_item_i   (sel_item_i),
    .disp_req_o   (disp_req_o),
    .disp_item_o  (disp_item_o),
    .disp_done_i  (disp_done_i),
    .chg_req_o    (chg_req_o),
    .chg_coin_o   (chg_coin_o),
    .chg_ack_i    (chg_ack_i),
    .credit_o     (credit_o),
    .coin_reject_o(coin_reject_o),
    .err_funds_o  (err_funds_o),
    .vend_done_o  (vend_done_o),
    .busy_o       (busy_o)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_fail = 0;
  int got_done = 0, got_rej = 0, got_err = 0;
  int exp_done = 0, exp_rej = 0, exp_err = 0;
  int got_disp[$], exp_disp[$], got_chg[$], exp_chg[$];
  int disp_idx = 0, chg_idx = 0;
  int m_credit = 0;
  int m_item = 0;
  logic hop_hold = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic int greedy(input int a);
    if (a >= 10) return 10;
    if (a >= 5) return 5;
    return 1;
  endfunction

  function automatic int price_of(input int item);
    case (item)
      1:       return 40;
      2:       return 20;
      3:       return 50;
      default: return 0;
    endcase
  endfunction

  task automatic push_change(input int a);
    repeat (a / 10) exp_chg.push_back(10);
    repeat ((a % 10) / 5) exp_chg.push_back(5);
    repeat (a % 5) exp_chg.push_back(1);
  endtask

  // Compare process: protocol and greedy-choice checks every cycle, event logging for the model
  initial begin
    logic prev_disp = 1'b0;
    logic prev_chg = 1'b0;
    int   prev_coin = 0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (disp_req_o) begin
          chk("disp_busy", busy_o, 1);
          chk("disp_item", disp_item_o, m_item);
          if (!prev_disp) got_disp.push_back(disp_item_o);
        end
        if (chg_req_o) begin
          if (!prev_chg) begin
            chk("chg_greedy", chg_coin_o, greedy(int'(credit_o)));
            got_chg.push_back(chg_coin_o);
          end else begin
            chk("chg_stable", chg_coin_o, prev_coin);
          end
        end
        if (vend_done_o) begin
          got_done++;
          chk("done_not_busy", busy_o, 0);
        end
        if (coin_reject_o) got_rej++;
        if (err_funds_o) got_err++;
      end
      prev_disp = disp_req_o;
      prev_chg  = chg_req_o;
      prev_coin = chg_coin_o;
    end
  end

  // Dispenser: completes 4 cycles after the request is seen
  initial begin
    int dcnt = 0;
    disp_done_i = 1'b0;
    forever begin
      @(negedge clk);
      disp_done_i = 1'b0;
      if (disp_req_o && !rst) begin
        dcnt++;
        if (dcnt == 4) begin
          disp_done_i = 1'b1;
          dcnt = 0;
        end
      end else begin
        dcnt = 0;
      end
    end
  end

  // Hopper: acks 2 cycles after the request unless held off
  initial begin
    int hcnt = 0;
    chg_ack_i = 1'b0;
    forever begin
      @(negedge clk);
      chg_ack_i = 1'b0;
      if (chg_req_o && !rst && !hop_hold) begin
        hcnt++;
        if (hcnt == 2) begin
          chg_ack_i = 1'b1;
          hcnt = 0;
        end
      end else begin
        hcnt = 0;
      end
    end
  end

  task automatic coin(input int v);
    @(negedge clk);
    coin_valid_i = 1'b1;
    coin_value_i = 4'(v);
    @(negedge clk);
    coin_valid_i = 1'b0;
    if (m_credit + v > 255) exp_rej++;
    else m_credit += v;
    chk("credit_after_coin", credit_o, m_credit);
  endtask

  task automatic wait_disp();
    bit seen = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (disp_req_o) begin
        seen = 1;
        break;
      end
    end
    chk("disp_req_seen", int'(seen), 1);
  endtask

  task automatic select(input int item);
    if (item != 0) m_item = item;
    @(negedge clk);
    sel_valid_i = 1'b1;
    sel_item_i  = 2'(item);
    @(negedge clk);
    sel_valid_i = 1'b0;
    if (item == 0) begin
      push_change(m_credit);
      m_credit = 0;
      exp_done++;
    end else if (m_credit >= price_of(item)) begin
      exp_disp.push_back(item);
      m_credit -= price_of(item);
      wait_disp();
      chk("credit_after_check", credit_o, m_credit);
      push_change(m_credit);
      m_credit = 0;
      exp_done++;
    end else begin
      exp_err++;
      repeat (3) @(negedge clk);
    end
  endtask

  task automatic wait_done(input int budget);
    for (int i = 0; i < budget; i++) begin
      @(posedge clk);
      if (got_done >= exp_done) break;
    end
    chk("vend_done_count", got_done, exp_done);
    repeat (2) @(negedge clk);
  endtask

  task automatic end_scn();
    chk("disp_count", got_disp.size(), exp_disp.size());
    for (int i = disp_idx; i < exp_disp.size() && i < got_disp.size(); i++)
      chk("disp_seq", got_disp[i], exp_disp[i]);
    chk("chg_count", got_chg.size(), exp_chg.size());
    for (int i = chg_idx; i < exp_chg.size() && i < got_chg.size(); i++)
      chk("chg_seq", got_chg[i], exp_chg[i]);
    disp_idx = exp_disp.size();
    chg_idx  = exp_chg.size();
    chk("reject_count", got_rej, exp_rej);
    chk("err_funds_count", got_err, exp_err);
    chk("idle_credit", credit_o, 0);
    chk("idle_busy", busy_o, 0);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_disp_req"}, disp_req_o, 0);
    chk({tag, "_disp_item"}, disp_item_o, 0);
    chk({tag, "_chg_req"}, chg_req_o, 0);
    chk({tag, "_chg_coin"}, chg_coin_o, 0);
    chk({tag, "_credit"}, credit_o, 0);
    chk({tag, "_coin_reject"}, coin_reject_o, 0);
    chk({tag, "_err_funds"}, err_funds_o, 0);
    chk({tag, "_vend_done"}, vend_done_o, 0);
    chk({tag, "_busy"}, busy_o, 0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit seen;
    rst = 1'b1;
    coin_valid_i = 1'b0;
    coin_value_i = 4'd0;
    sel_valid_i = 1'b0;
    sel_item_i = 2'd0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk_all_zero("reset");

    // Selection in IDLE is ignored
    sel_valid_i = 1'b1;
    sel_item_i  = 2'd1;
    @(negedge clk);
    sel_valid_i = 1'b0;
    repeat (3) @(negedge clk);
    chk("idle_sel_busy", busy_o, 0);
    chk("idle_sel_disp", got_disp.size(), 0);

    // Exact price: 4 x 10 for coke, no change
    repeat (4) coin(10);
    select(1);
    wait_done(100);
    chk("lit_s1_item", got_disp[got_disp.size() - 1], 1);
    chk("lit_s1_chg", got_chg.size(), 0);
    end_scn();

    // 30 for water, one 10 back
    coin(15);
    coin(15);
    select(2);
    wait_done(100);
    chk("lit_s2_chg", got_chg[got_chg.size() - 1], 10);
    end_scn();

    // Insufficient funds, then cancel
    coin(5);
    select(3);
    chk("lit_s3_credit", credit_o, 5);
    chk("lit_s3_err", got_err, 1);
    select(0);
    wait_done(100);
    chk("lit_s3_chg", got_chg[got_chg.size() - 1], 5);
    end_scn();

    // Overflow at 250 + 10, then full refund of 25 tens
    repeat (16) coin(15);
    coin(10);
    coin(10);
    chk("lit_s4_credit", credit_o, 250);
    select(0);
    wait_done(600);
    end_scn();

    // Coin during DISPENSE is rejected
    coin(10);
    coin(10);
    select(2);
    coin_valid_i = 1'b1;
    coin_value_i = 4'd5;
    @(negedge clk);
    coin_valid_i = 1'b0;
    exp_rej++;
    chk("s5_credit_kept", credit_o, 0);
    wait_done(100);
    end_scn();

    // Coin and selection in the same cycle: coin wins
    coin(10);
    @(negedge clk);
    coin_valid_i = 1'b1;
    coin_value_i = 4'd5;
    sel_valid_i  = 1'b1;
    sel_item_i   = 2'd1;
    @(negedge clk);
    coin_valid_i = 1'b0;
    sel_valid_i  = 1'b0;
    m_credit += 5;
    chk("lit_s6_credit", credit_o, 15);
    repeat (2) @(negedge clk);
    chk("s6_no_check", busy_o, 0);
    select(0);
    wait_done(100);
    end_scn();

    // Reset while chg_req is held
    coin(10);
    coin(1);
    hop_hold = 1'b1;
    @(negedge clk);
    sel_valid_i = 1'b1;
    sel_item_i  = 2'd0;
    @(negedge clk);
    sel_valid_i = 1'b0;
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      if (chg_req_o) begin
        seen = 1;
        break;
      end
      @(negedge clk);
    end
    chk("s7_chg_req_seen", int'(seen), 1);
    exp_chg.push_back(10);
    m_credit = 0;
    rst = 1'b1;
    @(negedge clk);
    chk_all_zero("midrst");
    rst = 1'b0;
    hop_hold = 1'b0;
    @(negedge clk);
    coin(1);
    select(0);
    wait_done(100);
    end_scn();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
